// File: rtl/histo_readout_seq.sv
// histo_readout_seq
//   Sweeps the histogram channel select through every channel, waits for the
//   trigger block's select-to-data pipeline to settle, snapshots the whole
//   histogram bank of that channel and streams it out word by word over a
//   valid/ready port. Runs entirely in the clk_adc domain.
//
//   Optional build macro: CLEAR_AFTER_READ_EN
//     defined   : a one-cycle resethist_req pulse follows the final word of a
//                 sweep (CLEAR state), and done comes one cycle later.
//     undefined : no CLEAR state, resethist_req is tied low.
//
//   Stream handshake: out_data/out_valid/out_last are registered. A word is
//   transferred on a clk_adc edge where out_valid && out_ready; while
//   out_ready is low all three outputs hold, for as long as the consumer
//   likes. out_valid never drops without a transfer.

module histo_readout_seq #(
  parameter int NCHAN  = 16,
  parameter int NHIST  = 8,
  parameter int WORDW  = 32,
  parameter int SETTLE = 3
) (
  input  logic                   clk_adc,
  input  logic                   reset,
  input  logic                   start,
  output logic [7:0]             histostosend,
  input  logic [NHIST*WORDW-1:0] histosout,
  output logic [WORDW-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            sweep_count,
  output logic                   resethist_req,
  output logic [1:0]             dbg_state_o
);

  // Index width for the histogram word counter (at least one bit).
  localparam int HW = (NHIST > 1) ? $clog2(NHIST) : 1;

  localparam logic [7:0]    CHAN_LAST = 8'(NCHAN - 1);
  localparam logic [HW-1:0] HIDX_LAST = HW'(NHIST - 1);
  // The settle counter is loaded with SETTLE-1 so that capture happens on
  // the SETTLE-th edge after the select changed.
  localparam logic [7:0]    CNT_INIT  = 8'(SETTLE - 1);

`ifdef CLEAR_AFTER_READ_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SEND   = 2'd2,
    CLEAR  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SEND   = 2'd2
  } state_e;
`endif

  state_e                 state_q, state_d;
  logic [7:0]             chan_q, chan_d;
  logic [HW-1:0]          hidx_q, hidx_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [NHIST*WORDW-1:0] shadow_q, shadow_d;
  logic [7:0]             sel_q, sel_d;
  logic [WORDW-1:0]       data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [15:0]            count_q, count_d;
`ifdef CLEAR_AFTER_READ_EN
  logic                   rhreq_q, rhreq_d;
`endif

  logic                   hs;
  logic [HW-1:0]          hidx_inc;
  logic [WORDW-1:0]       shadow_word;

  assign hs       = valid_q && out_ready;
  assign hidx_inc = hidx_q + 1'b1;

  // Pick the next shadow word to present after a mid-channel handshake.
  always_comb begin
    shadow_word = '0;
    for (int h = 0; h < NHIST; h++) begin
      if (hidx_inc == HW'(h)) begin
        shadow_word = shadow_q[h*WORDW +: WORDW];
      end
    end
  end

  // Next-state and output-register logic for the sweep sequencer.
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    hidx_d   = hidx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    count_d  = count_q;
`ifdef CLEAR_AFTER_READ_EN
    rhreq_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // start is only looked at here, so a start while busy is dropped.
        if (start) begin
          sel_d   = 8'd0;
          chan_d  = 8'd0;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          state_d = SELECT;
        end
      end

      SELECT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          // The whole bank is taken on one edge so all words of a channel
          // share the same sample, no matter how long the consumer stalls.
          shadow_d = histosout;
          hidx_d   = '0;
          data_d   = histosout[WORDW-1:0];
          valid_d  = 1'b1;
          last_d   = (chan_q == CHAN_LAST) && (NHIST == 1);
          state_d  = SEND;
        end
      end

      SEND: begin
        if (hs) begin
          if (hidx_q != HIDX_LAST) begin
            hidx_d = hidx_inc;
            data_d = shadow_word;
            last_d = (chan_q == CHAN_LAST) && (hidx_inc == HIDX_LAST);
          end else if (chan_q != CHAN_LAST) begin
            // Move the select on and let the trigger pipeline settle again.
            chan_d  = chan_q + 8'd1;
            sel_d   = chan_q + 8'd1;
            cnt_d   = CNT_INIT;
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = SELECT;
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
`ifdef CLEAR_AFTER_READ_EN
            rhreq_d = 1'b1;
            state_d = CLEAR;
`else
            done_d  = 1'b1;
            busy_d  = 1'b0;
            count_d = count_q + 16'd1;
            sel_d   = 8'd0;
            state_d = IDLE;
`endif
          end
        end
      end

`ifdef CLEAR_AFTER_READ_EN
      CLEAR: begin
        // resethist_req falls here via its default; the sweep completes.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        count_d = count_q + 16'd1;
        sel_d   = 8'd0;
        state_d = IDLE;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any sweep and drops the word.
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      state_q  <= IDLE;
      chan_q   <= 8'd0;
      hidx_q   <= '0;
      cnt_q    <= 8'd0;
      shadow_q <= '0;
      sel_q    <= 8'd0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      hidx_q   <= hidx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

`ifdef CLEAR_AFTER_READ_EN
  // Histogram clear request register, one cycle wide after the final word.
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      rhreq_q <= 1'b0;
    end else begin
      rhreq_q <= rhreq_d;
    end
  end

  assign resethist_req = rhreq_q;
`else
  assign resethist_req = 1'b0;
`endif

  assign histostosend = sel_q;
  assign out_data     = data_q;
  assign out_valid    = valid_q;
  assign out_last     = last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sweep_count  = count_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_histo_readout_seq.sv
// Bench for histo_readout_seq: a histogram-bank model with a two-register
// select delay feeds the DUT; a transaction-level model predicts the word
// stream and the status outputs cycle by cycle.

module tb_histo_readout_seq;

  localparam int NCHAN  = 16;
  localparam int NHIST  = 8;
  localparam int WORDW  = 32;
  localparam int SETTLE = 3;
  localparam int W      = 16;

  // ---------------- clock / reset / DUT ----------------
  logic                   clk;
  logic                   reset;
  logic                   start;
  logic [7:0]             histostosend;
  logic [NHIST*WORDW-1:0] histosout;
  logic [WORDW-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   busy;
  logic                   done;
  logic [15:0]            sweep_count;
  logic                   resethist_req;
  logic [1:0]             dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  histo_readout_seq #(
    .NCHAN (NCHAN),
    .NHIST (NHIST),
    .WORDW (WORDW),
    .SETTLE(SETTLE)
  ) dut (
    .clk_adc      (clk),
    .reset        (reset),
    .start        (start),
    .histostosend (histostosend),
    .histosout    (histosout),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .sweep_count  (sweep_count),
    .resethist_req(resethist_req),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- histogram bank model ----------------
  logic [7:0]  sel_d1 = 8'd0;
  logic [7:0]  sel_d2 = 8'd0;
  logic [15:0] tick   = 16'd0;
  logic        age_on = 1'b0;

  always @(posedge clk) begin
    sel_d1 <= histostosend;
    sel_d2 <= sel_d1;
    tick   <= tick + 16'd1;
  end

  always_comb begin
    histosout = '0;
    for (int h = 0; h < NHIST; h++) begin
      histosout[h*WORDW +: WORDW] = {(age_on ? tick : 16'h0), sel_d2, 8'(h)};
    end
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- ready driver ----------------
  logic rdy_rand = 1'b0;
  logic rdy_hold = 1'b0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_hold)      out_ready = 1'b0;
      else if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
      else               out_ready = 1'b1;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // Sampled at negedge: inputs seen here are what the next posedge samples.
  logic [W-1:0] exp_q[$];
  logic         mon_en   = 1'b0;
  logic         m_busy   = 1'b0;
  logic         m_done   = 1'b0;
  logic         m_res    = 1'b0;
  logic         m_valid  = 1'b0;
  logic [15:0]  m_sweeps = 16'd0;
  logic [15:0]  exp_age  = 16'd0;
  int           gap_cd   = 0;
  logic         fin_ph   = 1'b0;
  logic         rst_chk  = 1'b0;
  int           words_done = 0;
  logic [W-1:0] cur;

  always @(negedge clk) begin
    if (mon_en) begin
      // compare current outputs with the model
      if (rst_chk) begin
        check_eq("rst_data", out_data, 32'h0);
        rst_chk = 1'b0;
      end
      check_eq("busy", busy, m_busy);
      check_eq("done", done, m_done);
      check_eq("sweep_count", sweep_count, m_sweeps);
      check_eq("resethist_req", resethist_req, m_res);
      check_eq("out_valid", out_valid, m_valid);
      check_eq("sel_range", histostosend < NCHAN, 1);
      if (m_valid) begin
        cur = exp_q[0];
        check_eq("out_data", out_data, {exp_age, cur});
        check_eq("out_last", out_last, exp_q.size() == 1);
        check_eq("sel_frozen", histostosend, cur[15:8]);
      end else begin
        check_eq("out_last_idle", out_last, 1'b0);
      end
      if (!m_busy) check_eq("sel_idle", histostosend, 8'd0);

      // advance the model across the coming edge
      if (reset) begin
        m_busy   = 1'b0;
        m_done   = 1'b0;
        m_res    = 1'b0;
        m_valid  = 1'b0;
        m_sweeps = 16'd0;
        exp_q.delete();
        gap_cd   = 0;
        fin_ph   = 1'b0;
        rst_chk  = 1'b1;
      end else begin
        m_done = 1'b0;
        m_res  = 1'b0;
        if (fin_ph) begin
          fin_ph   = 1'b0;
          m_done   = 1'b1;
          m_busy   = 1'b0;
          m_sweeps = m_sweeps + 16'd1;
        end else if (!m_busy) begin
          if (start) begin
            m_busy  = 1'b1;
            m_valid = 1'b0;
            gap_cd  = SETTLE;
            words_done = 0;
            exp_q.delete();
            for (int c = 0; c < NCHAN; c++)
              for (int h = 0; h < NHIST; h++)
                exp_q.push_back({8'(c), 8'(h)});
          end
        end else if (gap_cd > 0) begin
          gap_cd--;
          if (gap_cd == 0) begin
            m_valid = 1'b1;
            exp_age = age_on ? tick : 16'h0;
          end
        end else if (m_valid && out_ready) begin
          cur = exp_q.pop_front();
          words_done++;
          if (exp_q.size() == 0) begin
            m_valid = 1'b0;
`ifdef CLEAR_AFTER_READ_EN
            m_res  = 1'b1;
            fin_ph = 1'b1;
`else
            m_done   = 1'b1;
            m_busy   = 1'b0;
            m_sweeps = m_sweeps + 16'd1;
`endif
          end else if (cur[7:0] == 8'(NHIST - 1)) begin
            m_valid = 1'b0;
            gap_cd  = SETTLE;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (words_done < n && k < 5000) begin
      step();
      k++;
    end
    check_eq("words_wait", words_done >= n, 1'b1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < 5000) begin
      step();
      k++;
    end
    check_eq("done_wait", done, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    step();
    mon_en = 1'b1;
    step();
    step();
    reset = 1'b0;
    repeat (4) step();

    // reset mid-sweep at word 40
    pulse_start();
    wait_words(40);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("abort_valid", out_valid, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_sel", histostosend, 8'd0);
    repeat (5) step();

    // basic sweep with explicit first-word latency and ignored starts
    pulse_start();
    repeat (SETTLE - 1) step();
    check_eq("lat_before", out_valid, 1'b0);
    step();
    check_eq("lat_first", out_valid, 1'b1);
    check_eq("first_word", out_data, 32'h0000_0000);
    wait_words(5);
    pulse_start();
    wait_words(100);
    pulse_start();
    wait_done();
    check_eq("sweep1_count", sweep_count, 16'd1);
    // start one cycle after done begins sweep 2
    pulse_start();
    check_eq("restart_busy", busy, 1'b1);
    wait_done();
    check_eq("sweep2_count", sweep_count, 16'd2);
    repeat (3) step();

    // backpressure with a long mid-channel stall
    rdy_rand = 1'b1;
    pulse_start();
    wait_words(20);
    rdy_hold = 1'b1;
    repeat (50) step();
    rdy_hold = 1'b0;
    wait_done();
    check_eq("sweep3_count", sweep_count, 16'd3);
    repeat (3) step();

    // snapshot consistency with continuously changing counts
    age_on = 1'b1;
    pulse_start();
    wait_done();
    check_eq("sweep4_count", sweep_count, 16'd4);
    rdy_rand = 1'b0;
    repeat (5) step();
    check_eq("end_busy", busy, 1'b0);
    check_eq("end_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
